seq_addsub: RTL
===============

Name: seq_addsub

Overview:
Parametrised, multi-cycle adder/subtractor processing SLICE bits per clock through one shared ripple add/sub slice, with the carry held in a register between slices. Operands are captured on a start handshake. The result and flags (carry/borrow, signed overflow, zero) are presented with a one-cycle done pulse. It is the sequential, width-generic successor to the team's fixed 4-bit ripple adder-subtractor and lets wide datapaths trade latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SLICE
SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH
NSLICE, WIDTH/SLICE, derived localparam: cycles per operation

Ports:
clk    input   1      rising-edge clock
rst_n  input   1      asynchronous, active-low reset
start  input   1      request; sampled only when not busy
mode   input   1      0 = add, 1 = subtract (a - b); sampled with start
cin    input   1      carry-in for add; ignored in subtract mode
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
busy   output  1      high while an operation is in progress
done   output  1      one-cycle pulse; result and flags valid
sum    output  WIDTH  result, held until the next accepted start
cout   output  1      add: carry out; sub: 1 = no borrow (a >= b unsigned)
ovf    output  1      two's-complement overflow
zero   output  1      sum == 0

Behaviour:
- One clock and one reset: clk, rising edge; rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, zero=0. FSM returns to IDLE and internal operand, carry and index registers clear.
- FSM states:
  - IDLE: start=1 latches a, (b XOR {WIDTH{mode}}), and carry = mode ? 1 : cin. Sets slice index k=0 and moves to RUN; busy=1 from the next cycle.
  - RUN: each cycle computes slice k and writes sum[k*SLICE +: SLICE]. Updates the carry register and increments k. When k = NSLICE-1, it also registers cout, ovf and zero and moves to DONE.
  - DONE: done=1 for exactly this cycle and busy=0, then returns to IDLE.
  - A start sampled in DONE is accepted as in IDLE, so back-to-back operations lose no cycle.
- Latency: start sampled at edge E0; done is high in the cycle after edge E(NSLICE). With SLICE=WIDTH, done follows one cycle after the RUN cycle.
- start while busy=1 is ignored; a, b, mode and cin may change freely during RUN.
- Flags:
  - ovf = carry into MSB XOR carry out of MSB, taken from the final slice.
  - zero is computed on the complete WIDTH-bit result.
  - cout is the raw carry out in both modes; no inversion for borrow.
- Arithmetic is modulo 2^WIDTH. Unsigned wrap is reported only through cout.
- sum, cout, ovf and zero hold their last values between done pulses. During RUN, sum shows partially updated slices and is not valid until done.
- Reset mid-operation: everything clears immediately and no done is produced for the aborted operation.

Decomposition:
- Shared package: add/sub mode encoding constants (MODE_ADD=0, MODE_SUB=1) and the FSM state typedef (IDLE, RUN, DONE).
- One sub-module, addsub_slice: combinational SLICE-bit ripple adder on pre-inverted b.
  - Outputs: s[SLICE], co, and c_msb (carry into the slice's top bit) for the overflow calculation.
  - Instantiated once and reused each cycle.

Test Plan:
1. Add: WIDTH=16/SLICE=4, a=0x1234, b=0x0FFF, mode=0, cin=0 -> sum=0x2233, cout=0, ovf=0, zero=0; done exactly 4 cycles after the start edge, busy high for 4 cycles.
2. Subtract with borrow: a=0x0008, b=0x000C, mode=1 -> sum=0xFFFC, cout=0, ovf=0. Then a=b=0x5A5A, mode=1 -> sum=0x0000, zero=1, cout=1.
3. Overflow: add 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0. Subtract 0x8000-0x0001 -> sum=0x7FFF, ovf=1, cout=1. Add 0xFFFF+0x0000, cin=1 -> sum=0x0000, cout=1, zero=1, ovf=0.
4. Handshake:
   - Pulse start again at cycle 2 of an operation -> ignored, single done.
   - Assert start in the DONE cycle -> new operation accepted, next done 4 cycles later.
   - Change a/b during RUN -> result unaffected.
5. Reset mid-operation: drop rst_n for 1 cycle during RUN slice 2 -> all outputs 0 at once, no done, IDLE. Next start completes normally.
6. Parameter sweep: WIDTH=8/SLICE=8 (1 cycle), WIDTH=8/SLICE=1 (8 cycles), WIDTH=32/SLICE=8 with randomised operands and modes -> sum/cout/ovf/zero match a reference model; done latency = NSLICE.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor.
// Mode encoding and controller state type.
package seq_addsub_pkg;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

endpackage

// File: rtl/seq_addsub_addsub.sv
// Combinational SLICE-bit ripple adder on pre-inverted b.
// Reports carry out and carry into the slice's top bit.
module addsub_slice #(
   parameter int SLICE = 4
) (
   input  logic [SLICE-1:0] a_i,
   input  logic [SLICE-1:0] b_i,
   input  logic             c_i,
   output logic [SLICE-1:0] s_o,
   output logic             co_o,
   output logic             cmsb_o
);

   logic [SLICE:0] t_w;

   // Slice sum; top-bit carry-in recovered from the sum bit
   always_comb begin
      t_w = {1'b0, a_i} + {1'b0, b_i}
          + {{SLICE{1'b0}}, c_i};
      s_o    = t_w[SLICE-1:0];
      co_o   = t_w[SLICE];
      cmsb_o = t_w[SLICE-1] ^ a_i[SLICE-1] ^ b_i[SLICE-1];
   end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/sub: one SLICE-bit slice per clock,
// carry held in a register between slices.
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef logic [KW-1:0] idx_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             c_q;
   idx_t             k_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;

   logic [SLICE-1:0] sa_w;
   logic [SLICE-1:0] sb_w;
   logic [SLICE-1:0] s_w;
   logic             co_w;
   logic             cmsb_w;
   logic             last_w;

   // Select the current operand slice and merge its result
   always_comb begin
      sa_w   = a_q[k_q*SLICE +: SLICE];
      sb_w   = b_q[k_q*SLICE +: SLICE];
      last_w = (k_q == idx_t'(NSLICE - 1));
      sum_d  = sum_q;
      sum_d[k_q*SLICE +: SLICE] = s_w;
   end

   addsub_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a_i    (sa_w),
      .b_i    (sb_w),
      .c_i    (c_q),
      .s_o    (s_w),
      .co_o   (co_w),
      .cmsb_o (cmsb_w)
   );

   // Controller, operand capture and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{mode}};
                  c_q     <= (mode == MODE_SUB) ? 1'b1 : cin;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               sum_q <= sum_d;
               c_q   <= co_w;
               if (last_w) begin
                  cout_q  <= co_w;
                  ovf_q   <= co_w ^ cmsb_w;
                  zero_q  <= (sum_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;
   assign zero = zero_q;

endmodule
